// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Accept (IDLE) -> one execute cycle (EXEC) -> response held until consumed (RESP).
// Build option: define ALU_ARB_RR_EN for round-robin tie-break; otherwise
// requester 0 wins every tie and no last-grant register exists.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [2:0]  r0_op,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [2:0]  r1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_eq,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_eq
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  opc_q, opc_d;
  logic        owner_q, owner_d;
  logic [31:0] res_c_q, res_c_d;
  logic        res_eq_q, res_eq_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic        tie_pick;
  logic        grant;
  logic        accept;

`ifdef ALU_ARB_RR_EN
  logic        last_q, last_d;
  assign tie_pick = ~last_q;
`else
  assign tie_pick = 1'b0;
`endif

  // Pick the winning requester: a lone requester wins, ties go to tie_pick.
  always_comb begin
    grant = 1'b0;
    if (r0_valid && r1_valid) grant = tie_pick;
    else if (r1_valid)        grant = 1'b1;
  end

  assign r0_ready = (state_q == IDLE) && !grant && r0_valid;
  assign r1_ready = (state_q == IDLE) &&  grant && r1_valid;
  assign accept   = r0_ready || r1_ready;

  // Next-state and datapath capture for the accept/execute/respond sequence.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    owner_d  = owner_q;
    res_c_d  = res_c_q;
    res_eq_d = res_eq_q;
`ifdef ALU_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = grant ? r1_a  : r0_a;
          opb_d   = grant ? r1_b  : r0_b;
          opc_d   = grant ? r1_op : r0_op;
          owner_d = grant;
`ifdef ALU_ARB_RR_EN
          last_d  = grant;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_c_d  = alu_c;
        res_eq_d = alu_eq;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Response valids are registered so they come straight from flops.
    rsp0_valid_d = (state_d == RESP) && !owner_d;
    rsp1_valid_d = (state_d == RESP) &&  owner_d;
  end

  // State and data registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      opc_q        <= 3'd0;
      owner_q      <= 1'b0;
      res_c_q      <= 32'd0;
      res_eq_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      opc_q        <= opc_d;
      owner_q      <= owner_d;
      res_c_q      <= res_c_d;
      res_eq_q     <= res_eq_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_c      = res_c_q;
  assign rsp_eq     = res_eq_q;
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_op     = opc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: supplies the shared ALU, drives directed and
// random requests, and compares against a transaction-level reference.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]  r0_op, r1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_c;
  logic        rsp_eq;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        alu_eq;

  int total = 0;
  int bad   = 0;
  bit model_last;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_c(rsp_c), .rsp_eq(rsp_eq),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_eq(alu_eq)
  );

  // ALU semantics: wrap-around add/sub, logic ops, full-width shift amounts.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (b >= 32) ? 32'd0 : (a >> b[4:0]);
      3'd5:    return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // The shared ALU seen by the arbiter.
  always_comb begin
    alu_c  = alu_ref(alu_op, alu_a, alu_b);
    alu_eq = (alu_a == alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit tie_winner();
`ifdef ALU_ARB_RR_EN
    return !model_last;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_req(input bit n, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    if (n) begin r1_a = a; r1_b = b; r1_op = op; end
    else   begin r0_a = a; r0_b = b; r0_op = op; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r0_valid = 0; r1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_last = 1'b1;
  endtask

  // One transaction: accept, one execute cycle, response held for hold+1 cycles.
  task automatic transact(input bit v0, input bit v1, input int hold, input bit stall,
                          output logic [31:0] oc, output logic oe);
    bit g, loser_v;
    logic [31:0] ea, eb, ec;
    logic [2:0] eo;
    logic ee;
    @(posedge clk); #1;
    r0_valid = v0; r1_valid = v1; rsp0_ready = 0; rsp1_ready = 0;
    g = (v0 && v1) ? tie_winner() : v1;
    model_last = g;
    ea = g ? r1_a : r0_a;
    eb = g ? r1_b : r0_b;
    eo = g ? r1_op : r0_op;
    ec = alu_ref(eo, ea, eb);
    ee = (ea == eb);
    loser_v = (g ? v0 : v1) || stall;
    oc = 32'hx; oe = 1'bx;
    @(negedge clk);
    check("accept_r0_ready", r0_ready, !g);
    check("accept_r1_ready", r1_ready, g);
    @(posedge clk); #1;
    if (g) begin r1_valid = 0; r0_valid = loser_v; end
    else   begin r0_valid = 0; r1_valid = loser_v; end
    @(negedge clk);
    check("exec_rsp0_valid", rsp0_valid, 0);
    check("exec_rsp1_valid", rsp1_valid, 0);
    check("exec_alu_a", alu_a, ea);
    check("exec_alu_b", alu_b, eb);
    check("exec_alu_op", alu_op, eo);
    check("exec_loser_ready", g ? r0_ready : r1_ready, 0);
    // Non-owner response ready is raised to show it is ignored.
    if (g) rsp0_ready = 1; else rsp1_ready = 1;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check("resp_own_valid", g ? rsp1_valid : rsp0_valid, 1);
      check("resp_other_valid", g ? rsp0_valid : rsp1_valid, 0);
      check("resp_c", rsp_c, ec);
      check("resp_eq", rsp_eq, ee);
      check("resp_loser_ready", g ? r0_ready : r1_ready, 0);
      oc = rsp_c; oe = rsp_eq;
      if (h == hold) begin
        if (g) rsp1_ready = 1; else rsp0_ready = 1;
      end
    end
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    check("done_rsp0_valid", rsp0_valid, 0);
    check("done_rsp1_valid", rsp1_valid, 0);
  endtask

  initial begin
    logic [31:0] oc;
    logic oe;
    bit g;
    r0_a = 0; r0_b = 0; r0_op = 0; r1_a = 0; r1_b = 0; r1_op = 0;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_c", rsp_c, 0);
    check("rst_rsp_eq", rsp_eq, 0);

    // Single op: 5 - 3.
    set_req(0, 32'd5, 32'd3, 3'b001);
    transact(1, 0, 0, 0, oc, oe);
    check("single_c", oc, 32'd2);
    check("single_eq", oe, 0);

    // Continuous tie with responses consumed at once: 3-cycle cadence.
    do_reset();
    set_req(0, 32'd1, 32'd1, 3'b000);
    set_req(1, 32'hF0, 32'h3C, 3'b010);
    @(posedge clk); #1;
    r0_valid = 1; r1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      g = tie_winner();
      model_last = g;
      @(negedge clk);
      check("tie_r0_ready", r0_ready, !g);
      check("tie_r1_ready", r1_ready, g);
      @(negedge clk);
      check("tie_exec_valid", {rsp1_valid, rsp0_valid}, 0);
      @(negedge clk);
      check("tie_rsp_valid", {rsp1_valid, rsp0_valid}, g ? 2'b10 : 2'b01);
      check("tie_rsp_c", rsp_c, g ? 32'h30 : 32'd2);
    end
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

    // Backpressure: sra held for 5 extra cycles while r0 waits.
    set_req(0, 32'd9, 32'd9, 3'b000);
    set_req(1, 32'h80000000, 32'd4, 3'b101);
    transact(0, 1, 5, 1, oc, oe);
    check("bp_c", oc, 32'hF8000000);

    // Boundaries.
    set_req(0, 32'hFFFFFFFF, 32'd1, 3'b000);
    transact(1, 0, 0, 0, oc, oe);
    check("wrap_c", oc, 32'd0);
    check("wrap_eq", oe, 0);
    set_req(1, 32'd7, 32'd7, 3'b111);
    transact(0, 1, 1, 0, oc, oe);
    check("undef_c", oc, 32'd0);
    check("undef_eq", oe, 1);
    set_req(0, 32'hDEADBEEF, 32'd32, 3'b100);
    transact(1, 0, 0, 0, oc, oe);
    check("srl32_c", oc, 32'd0);

    // Async reset in the middle of RESP.
    set_req(1, 32'h12345678, 32'h1, 3'b011);
    @(posedge clk); #1;
    r1_valid = 1;
    @(negedge clk);
    check("ar_r1_ready", r1_ready, 1);
    @(posedge clk); #1;
    r1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("ar_resp_valid", rsp1_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_rsp1_drop", rsp1_valid, 0);
    check("ar_rsp0_drop", rsp0_valid, 0);
    check("ar_alu_a", alu_a, 0);
    check("ar_alu_op", alu_op, 0);
    check("ar_rsp_c", rsp_c, 0);
    @(posedge clk); #1 reset = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    check("ar_after_valid", {rsp1_valid, rsp0_valid}, 0);
    set_req(0, 32'd100, 32'd58, 3'b001);
    transact(1, 0, 0, 0, oc, oe);
    check("ar_fresh_c", oc, 32'd42);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      int sel;
      for (int q = 0; q < 2; q++) begin
        logic [31:0] a, b;
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        if (op >= 3'd4) b = $urandom_range(0, 40);
        else if ($urandom_range(0, 3) == 0) b = a;
        else b = $urandom;
        set_req(q[0], a, b, op);
      end
      sel = $urandom_range(0, 2);
      transact(sel != 1, sel != 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), oc, oe);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
